// File: rtl/uart_pkg.sv
// Shared UART types: arbiter state encoding and the byte width of the TX channel.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } uart_arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin pick: first asserted request scanning last_ptr+1, last_ptr+2, ... mod NREQ.
module uart_rr_pick #(
    parameter int NREQ = 2,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_ptr,
    output logic [NREQ-1:0] onehot,
    output logic [IW-1:0]   idx,
    output logic            any
);

    logic [IW-1:0] k;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        k      = '0;
        // Offsets start at 1 so the previous owner is considered last.
        for (int i = 1; i <= NREQ; i++) begin
            k = IW'((int'(last_ptr) + i) % NREQ);
            if (!any && req[k]) begin
                any       = 1'b1;
                onehot[k] = 1'b1;
                idx       = k;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin sharing of uart_core's TX byte channel between NREQ requesters.
// Define UART_ARB_TIMEOUT_EN to force release of an owner that stalls mid-packet for TIMEOUT_CYC cycles.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ        = 2,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [NREQ*UART_DATA_W-1:0] req_data,
    input  logic [NREQ-1:0]             req_last,
    output logic [NREQ-1:0]             req_ready,
    output logic                        tx_valid,
    output logic [UART_DATA_W-1:0]      tx_data,
    input  logic                        tx_ready,
    output logic [NREQ-1:0]             grant,
    output logic                        busy,
    output logic                        timeout_pulse
);

    localparam int IW = $clog2(NREQ);

    uart_arb_state_t state, state_nxt;

    logic [NREQ-1:0] grant_q;
    logic [IW-1:0]   owner_q;
    logic [IW-1:0]   last_ptr_q;

    logic [NREQ-1:0] pick_onehot;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;

    logic owner_valid;
    logic handshake;
    logic pkt_end;
    logic to_hit;
    logic release_grant;

    uart_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req      (req_valid),
        .last_ptr (last_ptr_q),
        .onehot   (pick_onehot),
        .idx      (pick_idx),
        .any      (pick_any)
    );

    assign owner_valid   = req_valid[owner_q];
    assign handshake     = (state == ARB_BUSY) && owner_valid && tx_ready;
    assign pkt_end       = handshake && req_last[owner_q];
    assign release_grant = pkt_end || to_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: if (pick_any)      state_nxt = ARB_BUSY;
            ARB_BUSY: if (release_grant) state_nxt = ARB_IDLE;
        endcase
    end

    // Ownership is latched in IDLE and only dropped at packet end or forced release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q    <= '0;
            owner_q    <= '0;
            last_ptr_q <= IW'(NREQ - 1);
        end else if (state == ARB_IDLE) begin
            if (pick_any) begin
                grant_q <= pick_onehot;
                owner_q <= pick_idx;
            end
        end else if (release_grant) begin
            grant_q    <= '0;
            last_ptr_q <= owner_q;
        end
    end

    always_comb begin
        tx_valid  = 1'b0;
        tx_data   = '0;
        req_ready = '0;
        busy      = 1'b0;
        if (state == ARB_BUSY) begin
            busy      = 1'b1;
            tx_valid  = owner_valid;
            tx_data   = req_data[owner_q*UART_DATA_W +: UART_DATA_W];
            req_ready = grant_q & {NREQ{tx_ready}};
        end
    end

    assign grant = grant_q;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] to_cnt_q;

    // Counts consecutive owner-idle BUSY cycles; hit fires on the TIMEOUT_CYC-th one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else if (state == ARB_IDLE || handshake) begin
            to_cnt_q <= '0;
        end else if (!owner_valid) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end

    assign to_hit        = (state == ARB_BUSY) && !owner_valid && (to_cnt_q == CW'(TIMEOUT_CYC - 1));
    assign timeout_pulse = to_hit;
`else
    localparam logic TO_CFG_OK = (TIMEOUT_CYC >= 1);

    assign to_hit        = 1'b0;
    assign timeout_pulse = 1'b0 & TO_CFG_OK;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with NREQ=4, TIMEOUT_CYC=8; timeout scenario depends on UART_ARB_TIMEOUT_EN.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic [3:0]  grant;
    logic        busy;
    logic        timeout_pulse;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] sdata [4][16];
    logic       slast [4][16];
    int         slen  [4];
    int         sptr  [4];
    logic [7:0] log_d [$];
    int         log_g [$];

    uart_tx_arbiter #(
        .NREQ        (4),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .tx_valid      (tx_valid),
        .tx_data       (tx_data),
        .tx_ready      (tx_ready),
        .grant         (grant),
        .busy          (busy),
        .timeout_pulse (timeout_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input int i, input logic v, input logic [7:0] d, input logic l);
        req_valid[i]       = v;
        req_data[i*8 +: 8] = d;
        req_last[i]        = l;
    endtask

    task automatic clear_src();
        for (int i = 0; i < 4; i++) begin
            slen[i] = 0;
            sptr[i] = 0;
        end
        log_d.delete();
        log_g.delete();
    endtask

    // Requester models: present the queued byte, advance on an observed handshake.
    task automatic run_traffic(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) begin
                if (sptr[i] < slen[i]) drive(i, 1'b1, sdata[i][sptr[i]], slast[i][sptr[i]]);
                else                   drive(i, 1'b0, 8'h00, 1'b0);
            end
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    log_d.push_back(tx_data);
                    log_g.push_back(i);
                    sptr[i]++;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        tx_ready  = 1'b1;
        req_valid = 4'b0001;
        req_data  = '0;
        req_last  = '0;
        repeat (3) @(negedge clk);
        n_checks++; if (grant !== 4'b0000) $display("FAIL reset_grant: got %b want 0000", grant); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid: got %b want 0", tx_valid); else n_pass++;
        n_checks++; if (req_ready !== 4'b0000) $display("FAIL reset_req_ready: got %b want 0000", req_ready); else n_pass++;
        n_checks++; if (timeout_pulse !== 1'b0) $display("FAIL reset_timeout: got %b want 0", timeout_pulse); else n_pass++;
        n_checks++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h want 00", tx_data); else n_pass++;
        @(posedge clk); #1;
        req_valid = '0;
        rst_n     = 1'b1;
    endtask

    task automatic test_single();
        @(posedge clk); #1;
        drive(0, 1'b1, 8'h41, 1'b0);
        @(negedge clk);
        n_checks++; if (grant !== 4'b0000 || tx_valid !== 1'b0) $display("FAIL single_pre: grant=%b tx_valid=%b want 0000/0", grant, tx_valid); else n_pass++;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (grant !== 4'b0001 || busy !== 1'b1) $display("FAIL single_grant: grant=%b busy=%b want 0001/1", grant, busy); else n_pass++;
        n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) $display("FAIL single_byte0: valid=%b data=%h want 1/41", tx_valid, tx_data); else n_pass++;
        n_checks++; if (req_ready !== 4'b0001) $display("FAIL single_ready0: got %b want 0001", req_ready); else n_pass++;
        @(posedge clk); #1;
        drive(0, 1'b1, 8'h42, 1'b1);
        @(negedge clk);
        n_checks++; if (tx_data !== 8'h42 || grant !== 4'b0001 || req_ready[1] !== 1'b0) $display("FAIL single_byte1: data=%h grant=%b rdy1=%b want 42/0001/0", tx_data, grant, req_ready[1]); else n_pass++;
        @(posedge clk); #1;
        drive(0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || grant !== 4'b0000) $display("FAIL single_end: busy=%b grant=%b want 0/0000", busy, grant); else n_pass++;
    endtask

    task automatic test_two_packets();
        logic [7:0] exp_d [5];
        int         exp_g [5];
        exp_d = '{8'hA0, 8'hA1, 8'hA2, 8'hB0, 8'hB1};
        exp_g = '{0, 0, 0, 1, 1};
        // Single-byte packet from req1 leaves last_ptr=1.
        clear_src();
        sdata[1][0] = 8'h55; slast[1][0] = 1'b1; slen[1] = 1;
        run_traffic(4);
        n_checks++; if (log_d.size() != 1 || log_d[0] !== 8'h55) $display("FAIL setup_ptr: bytes=%0d want 1 byte 55", log_d.size()); else n_pass++;
        clear_src();
        sdata[0][0] = 8'hA0; slast[0][0] = 1'b0;
        sdata[0][1] = 8'hA1; slast[0][1] = 1'b0;
        sdata[0][2] = 8'hA2; slast[0][2] = 1'b1; slen[0] = 3;
        sdata[1][0] = 8'hB0; slast[1][0] = 1'b0;
        sdata[1][1] = 8'hB1; slast[1][1] = 1'b1; slen[1] = 2;
        run_traffic(12);
        n_checks++; if (log_d.size() != 5) $display("FAIL b2b_count: got %0d want 5", log_d.size()); else n_pass++;
        for (int k = 0; k < 5; k++) begin
            if (k < log_d.size()) begin
                n_checks++;
                if (log_d[k] !== exp_d[k] || log_g[k] != exp_g[k])
                    $display("FAIL b2b_order[%0d]: got %h from %0d want %h from %0d", k, log_d[k], log_g[k], exp_d[k], exp_g[k]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_stall();
        int bad = 0;
        int hs  = 0;
        @(posedge clk); #1;
        tx_ready = 1'b0;
        drive(1, 1'b1, 8'h77, 1'b1);
        @(posedge clk); #1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (tx_valid !== 1'b1 || tx_data !== 8'h77 || grant !== 4'b0010 || req_ready !== 4'b0000) bad++;
            if (req_valid[1] && req_ready[1]) hs++;
            @(posedge clk); #1;
        end
        tx_ready = 1'b1;
        @(negedge clk);
        if (req_valid[1] && req_ready[1]) hs++;
        @(posedge clk); #1;
        drive(1, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        if (req_valid[1] && req_ready[1]) hs++;
        n_checks++; if (bad != 0) $display("FAIL stall_hold: %0d bad cycles want 0", bad); else n_pass++;
        n_checks++; if (hs != 1) $display("FAIL stall_handshakes: got %0d want 1", hs); else n_pass++;
        n_checks++; if (busy !== 1'b0 || grant !== 4'b0000) $display("FAIL stall_end: busy=%b grant=%b want 0/0000", busy, grant); else n_pass++;
    endtask

    task automatic test_owner_stall();
        @(posedge clk); #1;
        tx_ready = 1'b1;
        drive(0, 1'b1, 8'h61, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        drive(0, 1'b0, 8'h00, 1'b0);
        drive(1, 1'b1, 8'h71, 1'b1);
`ifdef UART_ARB_TIMEOUT_EN
        for (int c = 1; c <= 10; c++) begin
            logic       exp_p;
            logic [3:0] exp_g;
            exp_p = (c == 8);
            exp_g = (c <= 8) ? 4'b0001 : ((c == 9) ? 4'b0000 : 4'b0010);
            @(negedge clk);
            n_checks++;
            if (timeout_pulse !== exp_p || grant !== exp_g)
                $display("FAIL timeout_cyc%0d: pulse=%b grant=%b want %b/%b", c, timeout_pulse, grant, exp_p, exp_g);
            else n_pass++;
            if (c < 10) begin
                @(posedge clk); #1;
            end
        end
        n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h71) $display("FAIL timeout_next: valid=%b data=%h want 1/71", tx_valid, tx_data); else n_pass++;
        @(posedge clk); #1;
        drive(1, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || grant !== 4'b0000) $display("FAIL timeout_end: busy=%b grant=%b want 0/0000", busy, grant); else n_pass++;
`else
        begin
            int bad = 0;
            for (int c = 1; c <= 20; c++) begin
                @(negedge clk);
                if (grant !== 4'b0001 || timeout_pulse !== 1'b0 || tx_valid !== 1'b0 || req_ready[1] !== 1'b0) bad++;
                @(posedge clk); #1;
            end
            n_checks++; if (bad != 0) $display("FAIL hold_no_timeout: %0d bad cycles want 0", bad); else n_pass++;
        end
        drive(0, 1'b1, 8'h62, 1'b1);
        @(negedge clk);
        n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h62 || grant !== 4'b0001) $display("FAIL hold_resume: valid=%b data=%h grant=%b want 1/62/0001", tx_valid, tx_data, grant); else n_pass++;
        @(posedge clk); #1;
        drive(0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || grant !== 4'b0000) $display("FAIL hold_release: busy=%b grant=%b want 0/0000", busy, grant); else n_pass++;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (grant !== 4'b0010 || tx_data !== 8'h71) $display("FAIL hold_next: grant=%b data=%h want 0010/71", grant, tx_data); else n_pass++;
        @(posedge clk); #1;
        drive(1, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL hold_end: busy=%b want 0", busy); else n_pass++;
`endif
    endtask

    task automatic test_reset_mid();
        clear_src();
        for (int k = 0; k < 5; k++) begin
            sdata[2][k] = 8'hC0 + 8'(k);
            slast[2][k] = (k == 4);
        end
        slen[2] = 5;
        run_traffic(3);
        @(posedge clk); #1;
        drive(2, 1'b1, sdata[2][2], 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (log_d.size() != 2) $display("FAIL rstmid_bytes: got %0d want 2", log_d.size()); else n_pass++;
        n_checks++; if (grant !== 4'b0000 || busy !== 1'b0) $display("FAIL rstmid_state: grant=%b busy=%b want 0000/0", grant, busy); else n_pass++;
        n_checks++; if (tx_valid !== 1'b0 || req_ready !== 4'b0000) $display("FAIL rstmid_outputs: valid=%b ready=%b want 0/0000", tx_valid, req_ready); else n_pass++;
        drive(2, 1'b0, 8'h00, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        clear_src();
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 3; k++) begin
                sdata[i][k] = 8'h10 + 8'(i);
                slast[i][k] = 1'b1;
            end
            slen[i] = 3;
        end
        run_traffic(30);
        n_checks++; if (log_d.size() != 12) $display("FAIL rr_count: got %0d want 12", log_d.size()); else n_pass++;
        for (int k = 0; k < 12; k++) begin
            if (k < log_d.size()) begin
                n_checks++;
                if (log_g[k] != (k % 4) || log_d[k] !== 8'h10 + 8'(k % 4))
                    $display("FAIL rr_order[%0d]: got %h from %0d want %h from %0d", k, log_d[k], log_g[k], 8'h10 + 8'(k % 4), k % 4);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_packets();
        test_stall();
        test_owner_stall();
        test_reset_mid();
        test_round_robin();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
